// File: rtl/apa102_matrix_scroller.sv
// apa102_matrix_scroller: scrolls 5x8 glyph columns across a serpentine APA102 matrix,
// streaming start frame, pixel words and end frame once per scroll step.
module apa102_matrix_scroller #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int ROW_OFS   = 1,
    parameter int CLK_DIV   = 1,
    parameter int FRAME_GAP = 0,
    parameter int SNAKE     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        dir,
    input  logic [4:0]  digit_in,
    input  logic        digit_valid,
    output logic        digit_ready,
    input  logic [23:0] fg_rgb,
    input  logic [23:0] bg_rgb,
    input  logic [4:0]  bright,
    output logic        sclk,
    output logic        sdo,
    output logic        busy,
    output logic        frame_done
);
    localparam int N  = ROWS * COLS;
    localparam int NE = (N + 63) / 64;
    localparam int CW = $clog2(N + NE + FRAME_GAP + 2);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int RW = $clog2(ROWS + 1);
    localparam int PW = $clog2(COLS + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_PIX   = 3'd2;
    localparam logic [2:0] S_END   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_UPD   = 3'd5;
    localparam logic [2:0] S_AFTER = (FRAME_GAP == 0) ? S_UPD : S_GAP;
    // 3x5 hex font, row-major top row first, MSB = leftmost; drawn in glyph columns 2..4
    localparam logic [14:0] FONT [16] = '{
        15'b111_101_101_101_111, 15'b010_110_010_010_111, 15'b111_001_111_100_111,
        15'b111_001_111_001_111, 15'b101_101_111_001_001, 15'b111_100_111_001_111,
        15'b111_100_111_101_111, 15'b111_001_001_001_001, 15'b111_101_111_101_111,
        15'b111_101_111_001_111, 15'b111_101_111_101_101, 15'b110_101_110_101_110,
        15'b111_100_100_100_111, 15'b110_101_101_101_110, 15'b111_100_111_100_111,
        15'b111_100_111_100_100
    };

    function automatic logic [4:0] glyph_col(input logic [4:0] g, input logic [2:0] ci);
        logic [4:0] c;
        c = '0;
        if (g == 5'd31) c = '1;
        else if (!g[4] && ci >= 3'd2 && ci <= 3'd4)
            for (int r = 0; r < 5; r++) c[r] = FONT[g[3:0]][4'(16 - 3 * r - int'(ci))];
        return c;
    endfunction

    logic [2:0]            state_q, state_d;
    logic [DW-1:0]         div_q;
    logic                  hi_q;
    logic [4:0]            bit_q;
    logic [CW-1:0]         cnt_q;
    logic [RW-1:0]         r_q;
    logic [PW-1:0]         p_q;
    logic [2:0]            gc_q;
    logic [4:0]            glyph_q, glyph_n;
    logic [COLS-1:0][4:0]  colbuf_q;
    logic [COLS:0][4:0]    shl, shr;
    logic [23:0]           fg_q, bg_q, rgb;
    logic [4:0]            bright_q, new_col, col;
    logic [31:0]           word;
    logic                  tick, bit_end, word_end, last_p, on;
    int                    cidx, ridx;

    always_comb begin
        tick = div_q == DW'(CLK_DIV - 1);
        bit_end = tick && hi_q;
        word_end = bit_end && bit_q == 5'd31;
        last_p = p_q == PW'(COLS - 1);
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = en ? S_START : S_IDLE;
            S_START: state_d = word_end ? S_PIX : S_START;
            S_PIX:   state_d = (word_end && cnt_q == CW'(N - 1)) ? S_END : S_PIX;
            S_END:   state_d = (word_end && cnt_q == CW'(NE - 1)) ? S_AFTER : S_END;
            S_GAP:   state_d = (cnt_q == CW'(FRAME_GAP - 1)) ? S_UPD : S_GAP;
            S_UPD:   state_d = en ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        glyph_n = (gc_q == 3'd0) ? (digit_valid ? digit_in : 5'd16) : glyph_q;
        new_col = glyph_col(glyph_n, dir ? 3'd7 - gc_q : gc_q);
        shl = {new_col, colbuf_q};
        shr = {colbuf_q, new_col};
        cidx = (SNAKE != 0 && r_q[0]) ? COLS - 1 - int'(p_q) : int'(p_q);
        ridx = int'(r_q) - ROW_OFS;
        col = '0;
        for (int i = 0; i < COLS; i++) if (cidx == i) col = colbuf_q[i];
        on = 1'b0;
        for (int j = 0; j < 5; j++) if (ridx == j) on = col[j];
        rgb = on ? fg_q : bg_q;
        word = {3'b111, bright_q, rgb[7:0], rgb[15:8], rgb[23:16]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            hi_q     <= 1'b0;
            bit_q    <= '0;
            cnt_q    <= '0;
            r_q      <= '0;
            p_q      <= '0;
            gc_q     <= '0;
            glyph_q  <= 5'd16;
            colbuf_q <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            bright_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                div_q <= '0;
                hi_q  <= 1'b0;
                bit_q <= '0;
                cnt_q <= '0;
                r_q   <= '0;
                p_q   <= '0;
            end else if (state_q == S_GAP) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (state_q == S_START || state_q == S_PIX || state_q == S_END) begin
                div_q <= tick ? '0 : div_q + 1'b1;
                if (tick) hi_q <= ~hi_q;
                if (bit_end) bit_q <= bit_q + 1'b1;
                if (word_end) cnt_q <= cnt_q + 1'b1;
                if (word_end && state_q == S_PIX) begin
                    p_q <= last_p ? '0 : p_q + 1'b1;
                    if (last_p) r_q <= r_q + 1'b1;
                end
            end
            if (state_d == S_START && state_q != S_START) begin
                fg_q     <= fg_rgb;
                bg_q     <= bg_rgb;
                bright_q <= bright;
            end
            if (state_q == S_UPD) begin
                glyph_q  <= glyph_n;
                gc_q     <= gc_q + 1'b1;
                colbuf_q <= dir ? shr[COLS-1:0] : shl[COLS:1];
            end
        end
    end

    assign sclk        = hi_q;
    assign sdo         = state_q == S_PIX && word[~bit_q];
    assign busy        = state_q != S_IDLE;
    assign frame_done  = state_q == S_UPD;
    assign digit_ready = frame_done && gc_q == 3'd0 && digit_valid;
endmodule

// File: tb/tb_apa102_matrix_scroller.sv
// tb_apa102_matrix_scroller: captures whole frames from the strip pins and compares
// every LED word against hand-computed pixel masks; a slow-clock instance checks timing.
module tb_apa102_matrix_scroller;
    typedef struct {
        logic        dir;
        logic [4:0]  digit;
        logic        valid;
        int          nupd;
        logic [4:0]  br;
        logic [63:0] mask;
        logic [15:0] rdy;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, en = 1'b0, dir = 1'b0, digit_valid = 1'b0;
    logic [4:0] digit_in = 5'd0, bright = 5'd31;
    logic [23:0] fg_rgb = 24'h0F0000, bg_rgb = 24'h000700;
    logic digit_ready, sclk, sdo, busy, frame_done;
    logic rdy5, sclk5, sdo5, busy5, fd5;
    int checks = 0, errors = 0, cyc = 0;

    logic fb [2200];
    logic cap [2200];
    int nb = 0, cap_nb = 0, fd_count = 0, fd_cyc = 0, fd_prev = 0, rdy_bad = 0;
    logic [15:0] rdy_mask = '0;
    int last_rise5 = -1, fd5_last = -1, fd5_int = 0, viol5 = 0;
    logic psclk = 0, psclk5 = 0, psdo5 = 0, prst = 1;

    apa102_matrix_scroller dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .digit_in(digit_in),
        .digit_valid(digit_valid), .digit_ready(digit_ready), .fg_rgb(fg_rgb),
        .bg_rgb(bg_rgb), .bright(bright), .sclk(sclk), .sdo(sdo), .busy(busy),
        .frame_done(frame_done)
    );

    apa102_matrix_scroller #(.CLK_DIV(3), .FRAME_GAP(5)) u5 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .digit_in(digit_in),
        .digit_valid(digit_valid), .digit_ready(rdy5), .fg_rgb(fg_rgb),
        .bg_rgb(bg_rgb), .bright(bright), .sclk(sclk5), .sdo(sdo5), .busy(busy5),
        .frame_done(fd5)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                nb = 0;
                fd_count = 0;
                rdy_mask = '0;
                last_rise5 = -1;
                fd5_last = -1;
            end else begin
                if (sclk && !psclk) begin
                    if (nb < 2200) fb[nb] = sdo;
                    nb++;
                end
                if (digit_ready && !frame_done) rdy_bad++;
                if (frame_done) begin
                    cap = fb;
                    cap_nb = nb;
                    nb = 0;
                    fd_count++;
                    fd_prev = fd_cyc;
                    fd_cyc = cyc;
                    if (digit_ready && fd_count < 16) rdy_mask[fd_count] = 1'b1;
                end
                if (sclk5 && !psclk5) begin
                    if (last_rise5 >= 0 && cyc - last_rise5 != 6) viol5++;
                    last_rise5 = cyc;
                end
                if (fd5) begin
                    last_rise5 = -1;
                    if (fd5_last >= 0) fd5_int = cyc - fd5_last;
                    fd5_last = cyc;
                end
                if (!prst && sdo5 != psdo5 && !(psclk5 && !sclk5)) viol5++;
            end
            psclk = sclk;
            psclk5 = sclk5;
            psdo5 = sdo5;
            prst = reset;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int base);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], cap[base + i]};
        return w;
    endfunction

    task automatic check_frame(input logic [63:0] m, input logic [4:0] br);
        logic [31:0] fgw, bgw;
        fgw = {3'b111, br, fg_rgb[7:0], fg_rgb[15:8], fg_rgb[23:16]};
        bgw = {3'b111, br, bg_rgb[7:0], bg_rgb[15:8], bg_rgb[23:16]};
        chk("nbits", 64'(cap_nb), 64'd2112);
        chk("start_frame", 64'(wd(0)), 64'd0);
        for (int k = 0; k < 64; k++)
            chk($sformatf("word%0d", k), 64'(wd(32 + 32 * k)), 64'(m[k] ? fgw : bgw));
        chk("end_frame", 64'(wd(2080)), 64'd0);
    endtask

    task automatic wait_fd(input int limit);
        int start, n;
        start = fd_count;
        n = 0;
        while (fd_count == start && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (fd_count == start) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout actual=none required=pulse within %0d cycles", limit);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_t v [4];
        int c0, tog;
        logic ps;
        v[0] = '{1'b0, 5'd31, 1'b0, 0, 5'd31, 64'h0, 16'h0000};
        v[1] = '{1'b0, 5'd31, 1'b1, 1, 5'd31, 64'h0000_0180_0180_0100, 16'h0002};
        v[2] = '{1'b1, 5'd31, 1'b1, 1, 5'd31, 64'h0000_8001_8001_8000, 16'h0002};
        v[3] = '{1'b0, 5'd31, 1'b1, 8, 5'd5, 64'h0000_FFFF_FFFF_FF00, 16'h0202};
        do_reset();
        chk("reset_outs", 64'({sclk, sdo, busy, digit_ready, frame_done}), 64'd0);
        chk("reset_outs_u5", 64'({sclk5, sdo5, busy5, rdy5, fd5}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            do_reset();
            dir = v[i].dir;
            digit_in = v[i].digit;
            digit_valid = v[i].valid;
            bright = v[i].br;
            en = 1'b1;
            c0 = cyc;
            for (int j = 0; j <= v[i].nupd; j++) wait_fd(5000);
            chk($sformatf("fd_period_%0d", i),
                64'(v[i].nupd == 0 ? fd_cyc - c0 : fd_cyc - fd_prev), 64'd4225);
            check_frame(v[i].mask, v[i].br);
            chk($sformatf("ready_updates_%0d", i), 64'(rdy_mask), 64'(v[i].rdy));
        end
        chk("u5_frame_period", 64'(fd5_int), 64'd12678);
        chk("u5_sclk_sdo_timing", 64'(viol5), 64'd0);
        chk("ready_outside_upd", 64'(rdy_bad), 64'd0);

        // abort mid-PIX with a full buffer, then expect a blank frame
        repeat (300) @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outs", 64'({sclk, sdo, busy, frame_done}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        digit_valid = 1'b0;
        bright = 5'd31;
        wait_fd(5000);
        check_frame(64'h0, 5'd31);

        // drop en mid-frame: frame and update finish, then the strip goes quiet
        do_reset();
        dir = 1'b0;
        digit_in = 5'd31;
        digit_valid = 1'b1;
        en = 1'b1;
        repeat (500) @(negedge clk);
        en = 1'b0;
        wait_fd(5000);
        @(negedge clk);
        chk("en_drop_busy", 64'(busy), 64'd0);
        tog = 0;
        ps = sclk;
        repeat (200) begin
            @(negedge clk);
            if (sclk != ps) tog++;
            ps = sclk;
        end
        chk("en_drop_sclk_edges", 64'(tog), 64'd0);
        chk("en_drop_updates", 64'(fd_count), 64'd1);
        en = 1'b1;
        wait_fd(5000);
        check_frame(64'h0000_0180_0180_0100, 5'd31);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
